// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - B3/S23 game-of-life cell store and generation engine
// Optional TORUS_WRAP_EN: neighbours wrap toroidally; otherwise off-grid cells count as dead.
module life_grid_engine #(
  parameter int GRID_W         = 6,
  parameter int GRID_H         = 6,
  parameter int COORD_W        = 4,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vga_vs,
  input  logic               run,
  input  logic               step,
  input  logic               load_en,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               load_val,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_alive,
  output logic               busy,
  output logic [15:0]        gen_count
);

  localparam int N     = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(N);
  localparam int FC_W  = $clog2(FRAMES_PER_GEN + 1);
  localparam logic [COORD_W-1:0] W_C     = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] H_C     = COORD_W'(GRID_H);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(N - 1);
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FRAMES_PER_GEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
  state_t state_q, state_d;

  logic [N-1:0]       cells, next_cells;
  logic               vs_prev;
  logic [FC_W-1:0]    frame_cnt;
  logic               frame_tick, auto_trig;
  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] cx, cy;
  logic               start, do_load, do_commit;
  logic [3:0]         ncount;
  logic               nxt_alive;
  int                 nx, ny;

  function automatic logic [IDX_W-1:0] lin(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return IDX_W'(int'(y) * GRID_W + int'(x));
  endfunction

  assign frame_tick = vs_prev & ~vga_vs;
  assign auto_trig  = run & frame_tick & (frame_cnt == FC_LAST);
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    do_load   = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      IDLE: begin
        // A write wins over a coincident trigger, which is then lost
        if (load_en) begin
          do_load = 1'b1;
        end else if (step || auto_trig) begin
          start   = 1'b1;
          state_d = CALC;
        end
      end
      CALC:    if (idx == LAST) state_d = COMMIT;
      COMMIT: begin
        do_commit = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Neighbour count of the cell at (cx,cy), always taken from the committed grid
  always_comb begin
    ncount = 4'd0;
    nx     = 0;
    ny     = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          nx = int'(cx) + dx;
          ny = int'(cy) + dy;
`ifdef TORUS_WRAP_EN
          if (nx < 0) nx = GRID_W - 1;
          else if (nx >= GRID_W) nx = 0;
          if (ny < 0) ny = GRID_H - 1;
          else if (ny >= GRID_H) ny = 0;
          ncount = ncount + {3'd0, cells[IDX_W'(ny * GRID_W + nx)]};
`else
          if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
            ncount = ncount + {3'd0, cells[IDX_W'(ny * GRID_W + nx)]};
`endif
        end
      end
    end
    nxt_alive = (ncount == 4'd3) | (cells[idx] & (ncount == 4'd2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cells      <= '0;
      next_cells <= '0;
      vs_prev    <= 1'b0;
      frame_cnt  <= '0;
      idx        <= '0;
      cx         <= '0;
      cy         <= '0;
      gen_count  <= 16'd0;
      rd_alive   <= 1'b0;
    end else begin
      vs_prev <= vga_vs;
      if (!run)
        frame_cnt <= '0;
      else if (frame_tick)
        frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;

      rd_alive <= (rd_x < W_C && rd_y < H_C) ? cells[lin(rd_x, rd_y)] : 1'b0;

      if (do_load && load_x < W_C && load_y < H_C)
        cells[lin(load_x, load_y)] <= load_val;

      if (start) begin
        idx <= '0;
        cx  <= '0;
        cy  <= '0;
      end else if (state_q == CALC) begin
        next_cells[idx] <= nxt_alive;
        idx             <= idx + 1'b1;
        if (cx == X_MAX) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end

      if (do_commit) begin
        cells     <= next_cells;
        gen_count <= gen_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - self-checking bench for life_grid_engine
module tb_life_grid_engine;
  localparam int GW = 6;
  localparam int GH = 6;
  localparam int N  = GW * GH;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vga_vs = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        load_en = 1'b0;
  logic        load_val = 1'b0;
  logic [3:0]  load_x = 4'd0;
  logic [3:0]  load_y = 4'd0;
  logic [3:0]  rd_x = 4'd0;
  logic [3:0]  rd_y = 4'd0;
  logic        rd_alive;
  logic        busy;
  logic [15:0] gen_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_grid[GH][GW];
  bit m_next[GH][GW];
  bit e_grid[GH][GW];
  bit m_busy = 1'b0;
  int m_gen  = 0;

  life_grid_engine #(.GRID_W(GW), .GRID_H(GH), .COORD_W(4), .FRAMES_PER_GEN(2)) dut (
    .clk(clk), .reset_n(reset_n), .vga_vs(vga_vs), .run(run), .step(step),
    .load_en(load_en), .load_x(load_x), .load_y(load_y), .load_val(load_val),
    .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_cell(input int x, input int y);
    if (x < 0 || x >= GW || y < 0 || y >= GH) return 1'b0;
    return m_grid[y][x];
  endfunction

  // Reference generation computed straight from the B3/S23 rule
  task automatic life_model();
    int n, xx, yy;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) begin
              xx = x + dx;
              yy = y + dy;
`ifdef TORUS_WRAP_EN
              n += int'(m_grid[(yy + GH) % GH][(xx + GW) % GW]);
`else
              n += int'(m_cell(xx, yy));
`endif
            end
        m_next[y][x] = (n == 3) || (m_grid[y][x] && n == 2);
      end
  endtask

  // Per-cycle compare: read port sweeps 0..7 on both axes, including off-grid coordinates
  initial begin
    forever begin
      @(negedge clk);
      check("rd_alive", rd_alive, m_cell(int'(rd_x), int'(rd_y)));
      check("busy", busy, m_busy);
      check("gen_count", gen_count, m_gen & 32'hFFFF);
      if (rd_x == 4'd7) begin
        rd_x = 4'd0;
        rd_y = (rd_y == 4'd7) ? 4'd0 : rd_y + 4'd1;
      end else begin
        rd_x = rd_x + 4'd1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_busy  = 1'b0;
    m_gen   = 0;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) m_grid[y][x] = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic load(input int x, input int y, input bit v);
    load_en  = 1'b1;
    load_x   = 4'(x);
    load_y   = 4'(y);
    load_val = v;
    idle(1);
    load_en = 1'b0;
    idle(1);
    if (x < GW && y < GH) m_grid[y][x] = v;
  endtask

  // Trigger one generation; the grid must stay busy for N+1 cycles and commit afterwards
  task automatic generation(input bit via_vs, input bit inject);
    if (via_vs) vga_vs = 1'b0;
    else        step   = 1'b1;
    idle(1);
    step   = 1'b0;
    vga_vs = 1'b1;
    life_model();
    m_busy = 1'b1;
    for (int k = 0; k < N + 1; k++) begin
      load_en  = inject && (k == 2);
      load_x   = 4'd4;
      load_y   = 4'd4;
      load_val = 1'b1;
      idle(1);
    end
    load_en = 1'b0;
    m_busy  = 1'b0;
    m_gen++;
    idle(1);
    m_grid = m_next;
  endtask

  task automatic vs_edge();
    vga_vs = 1'b0;
    idle(1);
    vga_vs = 1'b1;
    idle(3);
  endtask

  task automatic clr_e();
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) e_grid[y][x] = 1'b0;
  endtask

  task automatic check_pattern(input string name);
    int diffs = 0;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        if (m_grid[y][x] != e_grid[y][x]) diffs++;
    check(name, diffs, 0);
  endtask

  task automatic load_vbar();
    load(2, 1, 1'b1);
    load(2, 2, 1'b1);
    load(2, 3, 1'b1);
  endtask

  task automatic expect_vbar();
    clr_e();
    e_grid[1][2] = 1'b1;
    e_grid[2][2] = 1'b1;
    e_grid[3][2] = 1'b1;
  endtask

  task automatic expect_hbar();
    clr_e();
    e_grid[2][1] = 1'b1;
    e_grid[2][2] = 1'b1;
    e_grid[2][3] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    check("reset_gen", gen_count, 0);
    check("reset_busy", busy, 0);

    // Blinker oscillates between horizontal and vertical bars
    load_vbar();
    generation(1'b0, 1'b0);
    idle(70);
    expect_hbar();
    check_pattern("blinker_h");
    check("blinker_gen1", gen_count, 1);
    generation(1'b0, 1'b0);
    idle(70);
    expect_vbar();
    check_pattern("blinker_v");
    check("blinker_gen2", gen_count, 2);

    // Block still-life
    do_reset();
    load(1, 1, 1'b1);
    load(2, 1, 1'b1);
    load(1, 2, 1'b1);
    load(2, 2, 1'b1);
    repeat (3) generation(1'b0, 1'b0);
    idle(70);
    clr_e();
    e_grid[1][1] = 1'b1;
    e_grid[1][2] = 1'b1;
    e_grid[2][1] = 1'b1;
    e_grid[2][2] = 1'b1;
    check_pattern("block");
    check("block_gen3", gen_count, 3);

    // Edge blinker exercises the boundary handling
    do_reset();
    load(0, 0, 1'b1);
    load(0, 1, 1'b1);
    load(0, 2, 1'b1);
    generation(1'b0, 1'b0);
    idle(70);
    clr_e();
    e_grid[1][0] = 1'b1;
    e_grid[1][1] = 1'b1;
`ifdef TORUS_WRAP_EN
    e_grid[1][5] = 1'b1;
`endif
    check_pattern("edge_blinker");

    // Automatic run: generations on every second frame tick only while run=1
    do_reset();
    load_vbar();
    run = 1'b1;
    vs_edge();
    generation(1'b1, 1'b0);
    vs_edge();
    generation(1'b1, 1'b0);
    vs_edge();
    idle(5);
    check("auto_gen2", gen_count, 2);
    run = 1'b0;
    vs_edge();
    vs_edge();
    idle(70);
    check("auto_stopped", gen_count, 2);
    expect_vbar();
    check_pattern("auto_grid");

    // Writes while busy are dropped
    do_reset();
    generation(1'b0, 1'b1);
    idle(70);
    clr_e();
    check_pattern("busy_reject");
    check("busy_reject_gen", gen_count, 1);

    // Reset in the middle of CALC
    do_reset();
    load_vbar();
    step = 1'b1;
    idle(1);
    step   = 1'b0;
    m_busy = 1'b1;
    idle(10);
    reset_n = 1'b0;
    m_busy  = 1'b0;
    m_gen   = 0;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) m_grid[y][x] = 1'b0;
    idle(3);
    check("midreset_busy", busy, 0);
    check("midreset_gen", gen_count, 0);
    reset_n = 1'b1;
    idle(70);
    load_vbar();
    generation(1'b0, 1'b0);
    idle(70);
    expect_hbar();
    check_pattern("after_reset");
    check("after_reset_gen", gen_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
